// File: rtl/title_rom_arbiter_if.sv
// Shared title ROM bus between the sprite fetch units and the ROM arbiter.
// slave = arbiter side, master = requesters plus ROM model.
interface title_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    busy;

  modport slave (
    input  req, req_addr, mem_data,
    output gnt, mem_en, mem_addr,
    output rsp_valid, rsp_data, busy
  );

  modport master (
    output req, req_addr, mem_data,
    input  gnt, mem_en, mem_addr,
    input  rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/title_rom_arbiter.sv
// Round-robin read arbiter for the shared title/sprite block ROM.
// Option: TITLE_ARB_PRIO0_EN gives requester 0 absolute priority.
module title_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic clk_125MHz,
  input  logic reset_n,
  title_rom_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]     r_rr_ptr;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [RD_LAT:0]   r_vld;
  logic [PW-1:0]     r_id [RD_LAT+1];

  logic              w_found;
  logic              w_upd;
  logic [PW-1:0]     w_sel;
  logic [PW-1:0]     w_nxt;
  logic [PW:0]       w_s;
  logic [ADDR_W-1:0] w_addr;

  // pick the first requester at or after the pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_upd   = 1'b0;
    w_sel   = '0;
    w_s     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_s = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_s >= (PW+1)'(N_REQ))
        w_s = w_s - (PW+1)'(N_REQ);
      if (!w_found && bus.req[w_s[PW-1:0]]) begin
        w_found = 1'b1;
        w_upd   = 1'b1;
        w_sel   = w_s[PW-1:0];
      end
    end
`ifdef TITLE_ARB_PRIO0_EN
    // scanout path wins outright and leaves the rotation untouched
    if (bus.req[0]) begin
      w_found = 1'b1;
      w_upd   = 1'b0;
      w_sel   = '0;
    end
`else
`endif
    if (!reset_n) begin
      w_found = 1'b0;
      w_upd   = 1'b0;
    end
  end

  // next pointer, address mux and one-hot grant for the winner
  always_comb begin
    w_nxt  = (w_sel == PW'(N_REQ-1)) ? '0 : w_sel + PW'(1);
    w_addr = '0;
    bus.gnt = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_sel == PW'(j))
        w_addr = bus.req_addr[j*ADDR_W +: ADDR_W];
      bus.gnt[j] = w_found && (w_sel == PW'(j));
    end
  end

  // rotate pointer and launch the ROM access on a grant
  always_ff @(posedge clk_125MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr   <= '0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_mem_en <= w_found;
      if (w_found)
        r_mem_addr <= w_addr;
      if (w_upd)
        r_rr_ptr <= w_nxt;
    end
  end

  // in-flight tracker: stage 0 loads with mem_addr, last stage answers
  always_ff @(posedge clk_125MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int s = 0; s <= RD_LAT; s++)
        r_id[s] <= '0;
    end else begin
      r_vld <= {r_vld[RD_LAT-1:0], w_found};
      r_id[0] <= w_sel;
      for (int s = 1; s <= RD_LAT; s++)
        r_id[s] <= r_id[s-1];
    end
  end

  // tag returning ROM data with its owner
  always_comb begin
    bus.rsp_valid = '0;
    for (int j = 0; j < N_REQ; j++)
      bus.rsp_valid[j] = r_vld[RD_LAT] && (r_id[RD_LAT] == PW'(j));
  end

  assign bus.mem_en   = r_mem_en;
  assign bus.mem_addr = r_mem_addr;
  assign bus.rsp_data = bus.mem_data;
  assign bus.busy     = |r_vld;
endmodule

// File: tb/tb_title_rom_arbiter.sv
// Directed bench for title_rom_arbiter with a 2-cycle ROM model.
// Option: TITLE_ARB_PRIO0_EN switches to the priority scenario.
module tb_title_rom_arbiter;
  logic clk_125MHz = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] r_p1, r_p2;

  title_rom_arbiter_if #(.N_REQ(4), .ADDR_W(12), .DATA_W(32)) bus();

  title_rom_arbiter #(
    .N_REQ(4), .ADDR_W(12), .DATA_W(32), .RD_LAT(2)
  ) dut (
    .clk_125MHz(clk_125MHz),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk_125MHz = ~clk_125MHz;

  function automatic logic [31:0] rom(input logic [11:0] a);
    return {~a, 8'h5A, a};
  endfunction

  // two-register ROM: address edge to data is 2 cycles
  always @(posedge clk_125MHz) begin
    r_p1 <= rom(bus.mem_addr);
    r_p2 <= r_p1;
  end
  assign bus.mem_data = r_p2;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_125MHz);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    bus.req  = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    step();
    bus.req = 4'hF;
    @(negedge clk_125MHz);
    chk("rst_gnt", 64'(bus.gnt), 64'h0);
    chk("rst_en", 64'(bus.mem_en), 64'h0);
    chk("rst_addr", 64'(bus.mem_addr), 64'h0);
    chk("rst_rsp", 64'(bus.rsp_valid), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    step();
    bus.req = '0;
    reset_n = 1'b1;

    // single request from requester 2
    bus.req_addr[2*12 +: 12] = 12'h0A5;
    bus.req = 4'b0100;
    @(negedge clk_125MHz);
    chk("one_gnt", 64'(bus.gnt), 64'h4);
    step();
    bus.req = '0;
    @(negedge clk_125MHz);
    chk("one_en", 64'(bus.mem_en), 64'h1);
    chk("one_addr", 64'(bus.mem_addr), 64'h0A5);
    chk("one_busy", 64'(bus.busy), 64'h1);
    step();
    @(negedge clk_125MHz);
    chk("one_en_off", 64'(bus.mem_en), 64'h0);
    chk("one_rsp_early", 64'(bus.rsp_valid), 64'h0);
    step();
    @(negedge clk_125MHz);
    chk("one_rsp", 64'(bus.rsp_valid), 64'h4);
    chk("one_data", 64'(bus.rsp_data), 64'(rom(12'h0A5)));
    step();
    @(negedge clk_125MHz);
    chk("one_rsp_end", 64'(bus.rsp_valid), 64'h0);
    chk("one_idle", 64'(bus.busy), 64'h0);
    step();

`ifdef TITLE_ARB_PRIO0_EN
    do_reset();
    bus.req_addr = {12'h103, 12'h102, 12'h101, 12'h100};
    bus.req = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_125MHz);
      chk("prio_gnt0", 64'(bus.gnt), 64'h1);
      step();
    end
    bus.req = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_125MHz);
      chk("prio_alt", 64'(bus.gnt), (k % 2 == 0) ? 64'h2 : 64'h4);
      step();
    end
    bus.req = '0;
`else
    // all four requesting from reset
    do_reset();
    bus.req_addr = {12'h103, 12'h102, 12'h101, 12'h100};
    for (int k = 0; k < 11; k++) begin
      int j;
      bus.req = (k < 8) ? 4'hF : 4'h0;
      j = k - 3;
      @(negedge clk_125MHz);
      chk("fair_gnt", 64'(bus.gnt),
          (k < 8) ? (64'h1 << (k % 4)) : 64'h0);
      if (j >= 0 && j < 8) begin
        chk("fair_rsp", 64'(bus.rsp_valid), 64'h1 << (j % 4));
        chk("fair_data", 64'(bus.rsp_data),
            64'(rom(12'h100 + 12'(j % 4))));
      end else begin
        chk("fair_rsp_idle", 64'(bus.rsp_valid), 64'h0);
      end
      step();
    end

    // pointer at 1, only 0 and 3 requesting
    do_reset();
    bus.req_addr = {12'h333, 12'h222, 12'h111, 12'h000};
    bus.req = 4'b0001;
    @(negedge clk_125MHz);
    chk("skip_g0", 64'(bus.gnt), 64'h1);
    step();
    bus.req = 4'b1001;
    @(negedge clk_125MHz);
    chk("skip_g3", 64'(bus.gnt), 64'h8);
    step();
    @(negedge clk_125MHz);
    chk("skip_wrap0", 64'(bus.gnt), 64'h1);
    chk("skip_addr3", 64'(bus.mem_addr), 64'h333);
    step();
    @(negedge clk_125MHz);
    chk("skip_again3", 64'(bus.gnt), 64'h8);
    step();
    bus.req = '0;
`endif

    // back-to-back reads by requester 1
    do_reset();
    for (int k = 0; k < 7; k++) begin
      int j;
      bus.req = (k < 3) ? 4'b0010 : 4'b0000;
      bus.req_addr[1*12 +: 12] = 12'h010 + 12'(k);
      j = k - 3;
      @(negedge clk_125MHz);
      chk("b2b_gnt", 64'(bus.gnt), (k < 3) ? 64'h2 : 64'h0);
      chk("b2b_busy", 64'(bus.busy),
          (k >= 1 && k <= 5) ? 64'h1 : 64'h0);
      if (k >= 1 && k <= 3)
        chk("b2b_addr", 64'(bus.mem_addr), 64'(12'h010 + 12'(k - 1)));
      if (j >= 0 && j < 3) begin
        chk("b2b_rsp", 64'(bus.rsp_valid), 64'h2);
        chk("b2b_data", 64'(bus.rsp_data),
            64'(rom(12'h010 + 12'(j))));
      end else begin
        chk("b2b_rsp_idle", 64'(bus.rsp_valid), 64'h0);
      end
      step();
    end

    // reset one cycle after a grant kills the read
    do_reset();
    bus.req_addr[2*12 +: 12] = 12'h0A5;
    bus.req = 4'b0100;
    @(negedge clk_125MHz);
    chk("mid_gnt", 64'(bus.gnt), 64'h4);
    step();
    bus.req = '0;
    reset_n = 1'b0;
    #1;
    chk("mid_en", 64'(bus.mem_en), 64'h0);
    chk("mid_busy", 64'(bus.busy), 64'h0);
    @(negedge clk_125MHz);
    chk("mid_rsp", 64'(bus.rsp_valid), 64'h0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_125MHz);
      chk("mid_no_rsp", 64'(bus.rsp_valid), 64'h0);
      chk("mid_no_busy", 64'(bus.busy), 64'h0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/title_rom_arbiter.md
# title_rom_arbiter

Round-robin read arbiter that shares one single-port title/sprite block ROM (32-bit words, 12-bit word address) among several sprite fetch units. Examples are the win, lose and start title renderers, which each compute `(DrawX-X + (DrawY-Y)*W)/8` word addresses. The block grants one requester per cycle, drives the ROM address and enable, and tracks each in-flight read so returning data is tagged to its owner after the fixed ROM latency. It sits between the per-title palette/renderer modules and the shared `blk_mem_gen` instance in the VGA pixel path.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `ADDR_W`, default 12: ROM word-address width.
- `DATA_W`, default 32: ROM data width.
- `RD_LAT`, default 2: ROM read latency in cycles, from the address edge to valid `mem_data` (1..4).

Ports:
- `clk_125MHz`, in, 1: sole clock, all state on the rising edge.
- `reset_n`, in, 1: asynchronous assert, active-low reset.
- `req`, in, N_REQ: per-requester read request, level.
- `req_addr`, in, N_REQ*ADDR_W: packed addresses; requester i occupies bits `[i*ADDR_W +: ADDR_W]`.
- `gnt`, out, N_REQ: one-hot grant, combinational, same cycle as selection.
- `mem_en`, out, 1: ROM enable, registered.
- `mem_addr`, out, ADDR_W: ROM address, registered.
- `mem_data`, in, DATA_W: ROM `douta`.
- `rsp_valid`, out, N_REQ: one-hot, marks `rsp_data` as belonging to requester i.
- `rsp_data`, out, DATA_W: equals `mem_data`, passthrough.
- `busy`, out, 1: at least one read is in flight.

## Operation
- Each cycle the arbiter selects at most one i with `req[i]=1` and asserts `gnt[i]`. With no requests, `gnt=0`.
- Round-robin pointer `rr_ptr` (log2 N_REQ bits) marks the highest-priority index. The search runs `rr_ptr`, `rr_ptr+1`, … modulo N_REQ.
- On a grant to i, `rr_ptr` becomes `(i+1) mod N_REQ` at the next edge. Without a grant, `rr_ptr` holds.
- At the edge ending a grant cycle: `mem_addr <= req_addr[i]` and `mem_en <= 1`. Without a grant: `mem_en <= 0` and `mem_addr` holds.
- Requester protocol:
  - Hold `req` and `req_addr` stable until it sees `gnt`.
  - In the cycle after `gnt` it may deassert, keep `req` high with a new address (back-to-back issue), or change nothing (re-read).
  - Dropping `req` before grant is legal; that request is simply lost.
- In-flight tracking uses a shift register of RD_LAT+1 stages. Each stage holds {valid, id}. Stage 0 is loaded together with `mem_addr`.
- `rsp_valid[id]` is asserted from the last stage. Throughput is one read per cycle, with no limit on outstanding reads other than the pipeline depth.
- `busy` is the OR of all stage valid bits.
- Address contents are not range-checked; out-of-range addresses read whatever the ROM returns.

## Timing
- Reset values: `rr_ptr=0`, `mem_en=0`, `mem_addr=0`, all stage valids 0, so `rsp_valid=0` and `busy=0`.
- `gnt` is gated low while `reset_n=0`.
- Latency from `gnt[i]` in cycle t:
  - `mem_addr`/`mem_en` are valid in t+1.
  - `rsp_valid[i]` and matching `rsp_data` are valid in t+1+RD_LAT.
  - For RD_LAT=2, that is 3 cycles after the grant.
- A single requester holding `req` high is granted every cycle. With N requesters all requesting, each is granted once every N cycles.
- Simultaneous grant and response in the same cycle is normal pipelined operation; there is no conflict.
- Reset mid-operation clears all in-flight reads. No `rsp_valid` pulses after reset deassertion for reads issued before reset. The ROM output is ignored.
- `rr_ptr` wraps from N_REQ-1 to 0. For non-power-of-2 N_REQ, indices ≥ N_REQ never win.

## Configuration
- `TITLE_ARB_PRIO0_EN` defined:
  - Requester 0 (pixel scanout path) has absolute priority. Whenever `req[0]=1` it is granted and `rr_ptr` is unchanged.
  - The remaining requesters round-robin among themselves only when `req[0]=0`.
- Undefined: pure round-robin over all N_REQ requesters as above.

## Test plan
- Reset, then single request: `req=4'b0100`, `req_addr[2]=12'h0A5` in cycle t → `gnt=4'b0100` in t; `mem_en=1`, `mem_addr=12'h0A5` in t+1; `rsp_valid=4'b0100` with `rsp_data=mem_data` (ROM model word 0A5) in t+3 (RD_LAT=2).
- Fairness: `req=4'b1111` held for 8 cycles from reset → grant sequence 0,1,2,3,0,1,2,3, each `rsp_valid` arriving 3 cycles after its grant with the correct address data.
- Back-to-back: requester 1 keeps `req` high, address 12'h010, 12'h011, 12'h012 on consecutive grants → 3 consecutive `rsp_valid[1]` pulses with words 010, 011, 012; `busy` high for the span.
- Skip idle: `rr_ptr=1`, `req=4'b1001` → grant 3 first, then 0; `rr_ptr` wraps to 0 then 1.
- Reset mid-flight: grant requester 2 in t, pull `reset_n` low in t+1 for one cycle → no `rsp_valid` ever asserted for that read; `mem_en=0` and `busy=0` immediately on assertion.
- With `TITLE_ARB_PRIO0_EN`: `req=4'b0111` held for 4 cycles → `gnt=4'b0001` every cycle; drop `req[0]` → grants alternate 1,2.
